// File: rtl/bcount_sequencer.sv
// Sequencer for the bottle-count decrementer: loads an initial count, issues timed
// and manual decrement strobes with one-cycle datapath latency, and flags exhaustion.
module bcount_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned MAX_COUNT = 99
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             dec_req,
  input  logic [WIDTH-1:0] count_in,
  output logic             load_en,
  output logic [WIDTH-1:0] load_data,
  output logic             dec_en,
  output logic             running,
  output logic             done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   presc, presc_n;
  logic            pending, pending_n;
  logic            load_en_n, dec_en_n, running_n, done_n;
  logic [WIDTH-1:0] load_data_n;
  logic            tick, req, cooldown, count_zero;

  // A strobe issued this cycle is not yet visible on count_in, so it blocks the
  // next issue; this gives the two-cycle minimum spacing between dec_en pulses.
  assign cooldown   = dec_en | load_en;
  assign count_zero = (count_in == '0);
  assign tick       = (state == RUN) && (presc == TICK_LAST);
  assign req        = tick | (dec_req & (state != DONE));

  always_comb begin
    state_n     = state;
    presc_n     = presc;
    pending_n   = pending;
    load_en_n   = 1'b0;
    dec_en_n    = 1'b0;
    load_data_n = load_data;

    if (state == RUN) presc_n = tick ? '0 : presc + 1'b1;

    if (load) begin
      state_n     = IDLE;
      load_en_n   = 1'b1;
      load_data_n = (load_value > MAX_VAL) ? MAX_VAL : load_value;
      presc_n     = '0;
      pending_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state_n = RUN;
          presc_n = '0;
        end
        RUN: begin
          if (pause) state_n = PAUSE;
          else if (!cooldown && !pending && count_zero) state_n = DONE;
        end
        PAUSE: if (start) state_n = RUN;
        DONE: ;
        default: state_n = IDLE;
      endcase

      if (cooldown) begin
        if (req) pending_n = 1'b1;
      end else begin
        // Anything that cannot issue now (count exhausted) is discarded, not kept.
        pending_n = 1'b0;
        if ((req || pending) && !count_zero && state != DONE) dec_en_n = 1'b1;
      end
    end

    running_n = (state_n == RUN);
    done_n    = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      presc     <= '0;
      pending   <= 1'b0;
      load_en   <= 1'b0;
      load_data <= '0;
      dec_en    <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      pending   <= pending_n;
      load_en   <= load_en_n;
      load_data <= load_data_n;
      dec_en    <= dec_en_n;
      running   <= running_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_bcount_sequencer.sv
// Directed bench for bcount_sequencer with a simple decrementer model closing the loop.
module tb_bcount_sequencer;

  logic       clk, reset_n;
  logic       load, start, pause, dec_req;
  logic [7:0] load_value, count_in;
  logic       load_en, dec_en, running, done;
  logic [7:0] load_data;

  int checks = 0;
  int errors = 0;

  bcount_sequencer #(.WIDTH(8), .TICK_DIV(4), .MAX_COUNT(99)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .dec_req(dec_req), .count_in(count_in),
    .load_en(load_en), .load_data(load_data), .dec_en(dec_en),
    .running(running), .done(done)
  );

  // Decrementer datapath: count follows a strobe one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     count_in <= '0;
    else if (load_en) count_in <= load_data;
    else if (dec_en)  count_in <= count_in - 8'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       l;
    logic [7:0] lv;
    logic       s, p, q;
    logic       le;
    logic [7:0] ld;
    logic       de, r, d;
    logic [7:0] c;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int n, input int l, input int lv, input int s, input int p,
                     input int q, input int le, input int ld, input int de,
                     input int r, input int d, input int c);
    vec_t v;
    v.l = l[0]; v.lv = lv[7:0]; v.s = s[0]; v.p = p[0]; v.q = q[0];
    v.le = le[0]; v.ld = ld[7:0]; v.de = de[0]; v.r = r[0]; v.d = d[0]; v.c = c[7:0];
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int dec_seen;

    //     n  ld  lv  s  p  q | le ld de r  d  cnt
    add(1, 1,  3, 0, 0, 0,  1,  3, 0, 0, 0, 0);   // load 3
    add(1, 0,  0, 0, 0, 0,  0,  3, 0, 0, 0, 3);
    add(1, 0,  0, 1, 0, 0,  0,  3, 0, 1, 0, 3);   // start
    add(3, 0,  0, 0, 0, 0,  0,  3, 0, 1, 0, 3);
    add(1, 0,  0, 0, 0, 0,  0,  3, 1, 1, 0, 3);   // tick -> dec
    add(3, 0,  0, 0, 0, 0,  0,  3, 0, 1, 0, 2);
    add(1, 0,  0, 0, 0, 0,  0,  3, 1, 1, 0, 2);
    add(3, 0,  0, 0, 0, 0,  0,  3, 0, 1, 0, 1);
    add(1, 0,  0, 0, 0, 0,  0,  3, 1, 1, 0, 1);
    add(1, 0,  0, 0, 0, 0,  0,  3, 0, 1, 0, 0);
    add(1, 0,  0, 0, 0, 0,  0,  3, 0, 0, 1, 0);   // DONE
    add(1, 0,  0, 0, 0, 1,  0,  3, 0, 0, 1, 0);   // dec_req ignored in DONE
    add(1, 0,  0, 1, 0, 0,  0,  3, 0, 0, 1, 0);   // start ignored in DONE
    add(1, 1,  7, 0, 0, 0,  1,  7, 0, 0, 0, 0);   // load 7 exits DONE
    add(1, 0,  0, 0, 0, 0,  0,  7, 0, 0, 0, 7);
    add(1, 1, 200, 0, 0, 0, 1, 99, 0, 0, 0, 7);   // clamp
    add(1, 0,  0, 0, 0, 0,  0, 99, 0, 0, 0, 99);
    add(1, 1,  0, 0, 0, 0,  1,  0, 0, 0, 0, 99);  // load 0
    add(1, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    add(1, 0,  0, 1, 0, 0,  0,  0, 0, 1, 0, 0);   // start at zero
    add(2, 0,  0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
    add(1, 1,  5, 0, 0, 0,  1,  5, 0, 0, 0, 0);
    add(1, 0,  0, 0, 0, 0,  0,  5, 0, 0, 0, 5);
    add(1, 0,  0, 0, 0, 1,  0,  5, 1, 0, 0, 5);   // manual dec in IDLE
    add(1, 0,  0, 0, 0, 1,  0,  5, 0, 0, 0, 4);   // req during dec_en -> pending
    add(1, 0,  0, 0, 0, 0,  0,  5, 1, 0, 0, 4);
    add(1, 0,  0, 0, 0, 0,  0,  5, 0, 0, 0, 3);
    add(1, 0,  0, 0, 0, 1,  0,  5, 1, 0, 0, 3);
    add(1, 0,  0, 0, 0, 0,  0,  5, 0, 0, 0, 2);
    add(1, 0,  0, 0, 0, 1,  0,  5, 1, 0, 0, 2);
    add(1, 0,  0, 0, 0, 0,  0,  5, 0, 0, 0, 1);
    add(1, 0,  0, 0, 0, 1,  0,  5, 1, 0, 0, 1);   // two reqs at count 1
    add(1, 0,  0, 0, 0, 1,  0,  5, 0, 0, 0, 0);
    add(2, 0,  0, 0, 0, 0,  0,  5, 0, 0, 0, 0);   // pending discarded, stays IDLE
    add(1, 0,  0, 1, 0, 0,  0,  5, 0, 1, 0, 0);
    add(1, 0,  0, 0, 0, 0,  0,  5, 0, 0, 1, 0);
    add(1, 1,  5, 0, 0, 0,  1,  5, 0, 0, 0, 0);
    add(1, 0,  0, 0, 0, 0,  0,  5, 0, 0, 0, 5);
    add(1, 0,  0, 1, 0, 0,  0,  5, 0, 1, 0, 5);
    add(3, 0,  0, 0, 0, 0,  0,  5, 0, 1, 0, 5);
    add(1, 0,  0, 0, 0, 1,  0,  5, 1, 1, 0, 5);   // req merged with tick
    add(3, 0,  0, 0, 0, 0,  0,  5, 0, 1, 0, 4);
    add(1, 0,  0, 0, 0, 0,  0,  5, 1, 1, 0, 4);
    add(2, 0,  0, 0, 0, 0,  0,  5, 0, 1, 0, 3);
    add(1, 0,  0, 0, 1, 0,  0,  5, 0, 0, 0, 3);   // pause
    add(2, 0,  0, 0, 0, 0,  0,  5, 0, 0, 0, 3);
    add(1, 0,  0, 0, 0, 1,  0,  5, 1, 0, 0, 3);   // manual dec in PAUSE
    add(6, 0,  0, 0, 0, 0,  0,  5, 0, 0, 0, 2);
    add(1, 0,  0, 1, 0, 0,  0,  5, 0, 1, 0, 2);   // resume
    add(1, 0,  0, 0, 0, 0,  0,  5, 1, 1, 0, 2);
    add(1, 0,  0, 0, 0, 0,  0,  5, 0, 1, 0, 1);

    reset_n = 1'b0; load = 1'b0; load_value = '0; start = 1'b0; pause = 1'b0; dec_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load_en", int'(load_en), 0);
    chk("rst_load_data", int'(load_data), 0);
    chk("rst_dec_en", int'(dec_en), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      load = vq[i].l; load_value = vq[i].lv; start = vq[i].s;
      pause = vq[i].p; dec_req = vq[i].q;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_load_en", i), int'(load_en), int'(vq[i].le));
      chk($sformatf("v%0d_load_data", i), int'(load_data), int'(vq[i].ld));
      chk($sformatf("v%0d_dec_en", i), int'(dec_en), int'(vq[i].de));
      chk($sformatf("v%0d_running", i), int'(running), int'(vq[i].r));
      chk($sformatf("v%0d_done", i), int'(done), int'(vq[i].d));
      chk($sformatf("v%0d_count", i), int'(count_in), int'(vq[i].c));
    end
    load = 1'b0; start = 1'b0; pause = 1'b0; dec_req = 1'b0;

    // Asynchronous reset landing in a dec_en cycle.
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (dec_en) seen = 1'b1;
    end
    chk("rst_wait_dec_en", int'(seen), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_dec_en", int'(dec_en), 0);
    chk("arst_running", int'(running), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_load_en", int'(load_en), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_running", int'(running), 0);
    chk("post_rst_done", int'(done), 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("post_rst_start_running", int'(running), 1);
    chk("post_rst_start_dec_en", int'(dec_en), 0);
    @(posedge clk);
    #1;
    chk("post_rst_done", int'(done), 1);
    dec_seen = int'(dec_en);
    repeat (4) begin
      @(posedge clk);
      #1;
      dec_seen += int'(dec_en);
    end
    chk("post_rst_no_dec_en", dec_seen, 0);
    chk("post_rst_count", int'(count_in), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
